// File: rtl/mig_pkg.sv
// Shared operand encoding, node configuration record and FSM states for the MIG engine.
package mig_pkg;

  // Widest operand select any instance may use; node configs are stored at this width.
  localparam int unsigned SEL_MAX_W = 8;

  // Operand code 0 is constant 0, inputs start at 1, nodes follow the inputs.
  localparam int unsigned SEL_CONST0 = 0;
  localparam int unsigned SEL_X_BASE = 1;

  function automatic int unsigned sel_w_base(int unsigned n_in);
    return SEL_X_BASE + n_in;
  endfunction

  typedef struct packed {
    logic [SEL_MAX_W-1:0] op_a;
    logic [SEL_MAX_W-1:0] op_b;
    logic [SEL_MAX_W-1:0] op_c;
    logic [2:0]           inv;   // {c, b, a}
  } node_cfg_t;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StSweep,
    StFlush
  } state_e;

endpackage

// File: rtl/mig_node.sv
// One majority node: complements each operand as configured, then takes the 2-of-3 vote.
module mig_node (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_c,
  input  logic [2:0] i_inv,
  output logic       o_maj
);

  logic w_a;
  logic w_b;
  logic w_c;

  assign w_a   = i_a ^ i_inv[0];
  assign w_b   = i_b ^ i_inv[1];
  assign w_c   = i_c ^ i_inv[2];
  assign o_maj = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);

endmodule

// File: rtl/mig_tt_engine.sv
// Majority-inverter-graph truth-table engine: validates the node netlist, then sweeps every
// minterm and streams the selected signal's truth table as OUT_W-bit words.
module mig_tt_engine
  import mig_pkg::*;
#(
  parameter int unsigned N_IN    = 7,
  parameter int unsigned N_NODES = 6,
  parameter int unsigned OUT_W   = 32,
  localparam int unsigned SEL_W  = $clog2(1 + N_IN + N_NODES),
  localparam int unsigned NODE_W = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_we,
  input  logic [NODE_W-1:0] i_cfg_node,
  input  logic [SEL_W-1:0]  i_cfg_op_a,
  input  logic [SEL_W-1:0]  i_cfg_op_b,
  input  logic [SEL_W-1:0]  i_cfg_op_c,
  input  logic [2:0]        i_cfg_inv,
  input  logic [SEL_W-1:0]  i_cfg_out_sel,
  input  logic              i_cfg_out_inv,
  input  logic              i_cfg_out_we,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_tt_valid,
  input  logic              i_tt_ready,
  output logic [OUT_W-1:0]  o_tt_data,
  output logic              o_tt_last,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned N_SIG = sel_w_base(N_IN) + N_NODES;
  localparam int unsigned BIT_W = $clog2(OUT_W);

  if (((2 ** N_IN) % OUT_W) != 0) begin : g_bad_out_w
    $error("2^N_IN must be a multiple of OUT_W");
  end
  if (SEL_W > SEL_MAX_W) begin : g_bad_sel_w
    $error("operand select wider than SEL_MAX_W");
  end

  state_e            r_state;
  state_e            w_state_next;
  node_cfg_t         r_cfg [N_NODES];
  logic [SEL_W-1:0]  r_out_sel;
  logic              r_out_inv;
  logic [NODE_W:0]   r_chk;
  logic [N_IN-1:0]   r_m;
  logic [OUT_W-2:0]  r_acc;
  logic [OUT_W-1:0]  r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_done;
  logic              r_err;

  logic [N_SIG-1:0]  w_sig;
  logic [OUT_W-1:0]  w_word;
  logic              w_f;
  logic              w_chk_bad;
  logic              w_chk_done;
  logic              w_word_end;
  logic              w_last_m;
  logic              w_out_free;
  logic              w_xfer;

  // A node may only see signals before it, so each stage extends the visible vector by one.
  for (genvar j = 0; j < N_NODES; j++) begin : g_node
    localparam int unsigned AVW = sel_w_base(N_IN) + j;
    logic [AVW-1:0] w_avail;
    logic [2:0]     w_ops;
    logic           w_maj;

    if (j == 0) begin : g_first
      assign w_avail = {r_m, 1'b0};
    end else begin : g_chain
      assign w_avail = {g_node[j-1].w_maj, g_node[j-1].w_avail};
    end

    // Operand muxes; codes beyond the visible range read 0 and are rejected by CHECK.
    always_comb begin
      w_ops = '0;
      for (int k = 0; k < AVW; k++) begin
        if (r_cfg[j].op_a == SEL_MAX_W'(k)) w_ops[0] = w_avail[k];
        if (r_cfg[j].op_b == SEL_MAX_W'(k)) w_ops[1] = w_avail[k];
        if (r_cfg[j].op_c == SEL_MAX_W'(k)) w_ops[2] = w_avail[k];
      end
    end

    mig_node u_node (
      .i_a   (w_ops[0]),
      .i_b   (w_ops[1]),
      .i_c   (w_ops[2]),
      .i_inv (r_cfg[j].inv),
      .o_maj (w_maj)
    );
  end

  assign w_sig = {g_node[N_NODES-1].w_maj, g_node[N_NODES-1].w_avail};

  function automatic logic op_bad(node_cfg_t c, int unsigned j);
    int unsigned lim = sel_w_base(N_IN) + j;
    return (32'(c.op_a) >= lim) || (32'(c.op_b) >= lim) || (32'(c.op_c) >= lim);
  endfunction

  // Selected output signal for the current minterm.
  always_comb begin
    w_f = 1'b0;
    for (int k = 0; k < N_SIG; k++) begin
      if (r_out_sel == SEL_W'(k)) w_f = w_sig[k];
    end
    w_f = w_f ^ r_out_inv;
  end

  // Legality of the item examined this CHECK cycle: node r_chk, then the output select.
  always_comb begin
    w_chk_bad = 1'b0;
    for (int unsigned j = 0; j < N_NODES; j++) begin
      if (32'(r_chk) == j) w_chk_bad = op_bad(r_cfg[j], j);
    end
    if (32'(r_chk) == N_NODES) w_chk_bad = (32'(r_out_sel) >= N_SIG);
  end

  assign w_chk_done = (32'(r_chk) == N_NODES);
  assign w_word_end = &r_m[BIT_W-1:0];
  assign w_last_m   = &r_m;
  assign w_out_free = !r_out_valid || i_tt_ready;
  assign w_xfer     = r_out_valid && i_tt_ready;
  // New minterm enters at the top so minterm m ends at bit m mod OUT_W after a full word.
  assign w_word     = {w_f, r_acc};

  // Node and output configuration, writable only while idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < N_NODES; j++) r_cfg[j] <= '0;
      r_out_sel <= '0;
      r_out_inv <= 1'b0;
    end else if (r_state == StIdle) begin
      if (i_cfg_we && (32'(i_cfg_node) < N_NODES)) begin
        r_cfg[i_cfg_node] <= '{op_a: SEL_MAX_W'(i_cfg_op_a), op_b: SEL_MAX_W'(i_cfg_op_b),
                               op_c: SEL_MAX_W'(i_cfg_op_c), inv: i_cfg_inv};
      end
      if (i_cfg_out_we) begin
        r_out_sel <= i_cfg_out_sel;
        r_out_inv <= i_cfg_out_inv;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_next = StCheck;
      StCheck: begin
        if (w_chk_bad)       w_state_next = StIdle;
        else if (w_chk_done) w_state_next = StSweep;
      end
      StSweep: if (w_word_end && w_last_m && w_out_free) w_state_next = StFlush;
      StFlush: if (w_xfer) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Check counter, minterm sweep, accumulator, output word register and status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chk       <= '0;
      r_m         <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_xfer) r_out_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          r_chk <= '0;
          r_m   <= '0;
        end
        StCheck: begin
          r_chk <= r_chk + 1'b1;
          if (w_chk_bad) r_err <= 1'b1;
        end
        StSweep: begin
          // A completed word waits here (m holds) until the output register can take it.
          if (!w_word_end || w_out_free) begin
            r_m   <= r_m + 1'b1;
            r_acc <= w_word[OUT_W-1:1];
            if (w_word_end) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_word;
              r_out_last  <= w_last_m;
            end
          end
        end
        StFlush: if (w_xfer) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  // FSM / status outputs.
  always_comb begin
    o_busy     = (r_state != StIdle);
    o_tt_valid = r_out_valid;
    o_tt_data  = r_out_data;
    o_tt_last  = r_out_valid & r_out_last;
    o_done     = r_done;
    o_err      = r_err;
  end

endmodule

// File: tb/tb_mig_tt_engine.sv
// Directed bench for mig_tt_engine: table of netlist configs with expected truth-table words,
// plus hand-written stall, config-poke, illegal-config and mid-sweep reset sequences.
module tb_mig_tt_engine;

  localparam int unsigned N_IN    = 7;
  localparam int unsigned N_NODES = 6;
  localparam int unsigned OUT_W   = 32;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned NODE_W  = 3;
  localparam int          LAT     = N_NODES + 1 + OUT_W;
  localparam int          N_VEC   = 10;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_cfg_we = 1'b0;
  logic [NODE_W-1:0] i_cfg_node = '0;
  logic [SEL_W-1:0]  i_cfg_op_a = '0;
  logic [SEL_W-1:0]  i_cfg_op_b = '0;
  logic [SEL_W-1:0]  i_cfg_op_c = '0;
  logic [2:0]        i_cfg_inv = '0;
  logic [SEL_W-1:0]  i_cfg_out_sel = '0;
  logic              i_cfg_out_inv = 1'b0;
  logic              i_cfg_out_we = 1'b0;
  logic              i_start = 1'b0;
  logic              i_tt_ready = 1'b1;
  logic              o_busy;
  logic              o_tt_valid;
  logic [OUT_W-1:0]  o_tt_data;
  logic              o_tt_last;
  logic              o_done;
  logic              o_err;

  always #5 clk = ~clk;

  mig_tt_engine #(
    .N_IN    (N_IN),
    .N_NODES (N_NODES),
    .OUT_W   (OUT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_node    (i_cfg_node),
    .i_cfg_op_a    (i_cfg_op_a),
    .i_cfg_op_b    (i_cfg_op_b),
    .i_cfg_op_c    (i_cfg_op_c),
    .i_cfg_inv     (i_cfg_inv),
    .i_cfg_out_sel (i_cfg_out_sel),
    .i_cfg_out_inv (i_cfg_out_inv),
    .i_cfg_out_we  (i_cfg_out_we),
    .i_start       (i_start),
    .o_busy        (o_busy),
    .o_tt_valid    (o_tt_valid),
    .i_tt_ready    (i_tt_ready),
    .o_tt_data     (o_tt_data),
    .o_tt_last     (o_tt_last),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  typedef struct packed {
    logic [5:0][3:0]  op_a;
    logic [5:0][3:0]  op_b;
    logic [5:0][3:0]  op_c;
    logic [5:0][2:0]  inv;
    logic [3:0]       out_sel;
    logic             out_inv;
    logic [3:0][31:0] exp;    // exp[0] is the first word
  } vec_t;

  vec_t vecs [N_VEC];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_node(input int j, input int a, input int b, input int c,
                         input logic [2:0] inv);
    i_cfg_we   = 1'b1;
    i_cfg_node = NODE_W'(j);
    i_cfg_op_a = SEL_W'(a);
    i_cfg_op_b = SEL_W'(b);
    i_cfg_op_c = SEL_W'(c);
    i_cfg_inv  = inv;
    tick();
    i_cfg_we   = 1'b0;
  endtask

  task automatic wr_out(input int sel, input logic inv);
    i_cfg_out_we  = 1'b1;
    i_cfg_out_sel = SEL_W'(sel);
    i_cfg_out_inv = inv;
    tick();
    i_cfg_out_we  = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    for (int j = 0; j < 6; j++) wr_node(j, int'(v.op_a[j]), int'(v.op_b[j]), int'(v.op_c[j]),
                                        v.inv[j]);
    wr_out(int'(v.out_sel), v.out_inv);
  endtask

  function automatic vec_t mk1(input int a, input int b, input int c, input logic [2:0] inv,
                               input int sel, input logic oinv, input logic [3:0][31:0] exp);
    vec_t v = '0;
    v.op_a[0] = 4'(a);
    v.op_b[0] = 4'(b);
    v.op_c[0] = 4'(c);
    v.inv[0]  = inv;
    v.out_sel = 4'(sel);
    v.out_inv = oinv;
    v.exp     = exp;
    return v;
  endfunction

  // Start a sweep, collect four words and check data, tt_last, timing, done and busy.
  // hold: cycles tt_ready stays low after the first tt_valid. poke: drive config writes and
  // start during the sweep, which must all be ignored.
  task automatic sweep(input string tag, input logic [3:0][31:0] exp, input int hold,
                       input bit poke);
    logic [3:0][31:0] got = '0;
    logic [3:0]       lasts = '0;
    logic [31:0]      held = '0;
    int nw = 0, cyc = 0, t_first = -1, t_w0 = -1, t_w1 = -1, stall_left = 0, stall_bad = 0;
    i_tt_ready = 1'b1;
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
    while (nw < 4 && cyc < 4000) begin
      if (o_tt_valid && t_first < 0) begin
        t_first    = cyc;
        stall_left = hold;
        held       = o_tt_data;
      end
      i_tt_ready = (stall_left == 0);
      if (stall_left > 0) begin
        if (o_tt_data !== held || !o_busy || !o_tt_valid) stall_bad++;
        stall_left--;
      end
      if (o_tt_valid && i_tt_ready) begin
        got[nw]   = o_tt_data;
        lasts[nw] = o_tt_last;
        if (nw == 0) t_w0 = cyc;
        if (nw == 1) t_w1 = cyc;
        nw++;
      end
      if (poke) begin
        i_cfg_we      = (cyc >= 3 && cyc < 60);
        i_cfg_out_we  = i_cfg_we;
        i_start       = i_cfg_we;
        i_cfg_node    = NODE_W'(cyc % 6);
        i_cfg_op_a    = '0;
        i_cfg_op_b    = '0;
        i_cfg_op_c    = '0;
        i_cfg_out_sel = '0;
        i_cfg_out_inv = 1'b1;
      end
      tick();
      cyc++;
    end
    i_cfg_we     = 1'b0;
    i_cfg_out_we = 1'b0;
    i_start      = 1'b0;
    i_tt_ready   = 1'b1;
    check({tag, " word count"}, 32'(nw), 32'd4);
    for (int w = 0; w < 4; w++) check($sformatf("%s word%0d", tag, w), got[w], exp[w]);
    check({tag, " tt_last"}, 32'(lasts), 32'b1000);
    check({tag, " first valid latency"}, 32'(t_first), 32'(LAT));
    if (hold == 0) check({tag, " word spacing"}, 32'(t_w1 - t_w0), 32'(OUT_W));
    else           check({tag, " held while stalled"}, 32'(stall_bad), 32'd0);
    check({tag, " done pulse"}, 32'(o_done), 32'd1);
    check({tag, " busy after done"}, 32'(o_busy), 32'd0);
    tick();
    check({tag, " done one cycle"}, 32'(o_done), 32'd0);
  endtask

  // Start with an illegal config: exactly one err pulse at exp_cyc, never tt_valid.
  task automatic expect_err(input string tag, input int exp_cyc);
    int cyc = 0, n_err = 0, n_valid = 0, t_err = -1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check({tag, " busy in check"}, 32'(o_busy), 32'd1);
    while (cyc < 60) begin
      if (o_err) begin
        n_err++;
        if (t_err < 0) t_err = cyc;
      end
      if (o_tt_valid) n_valid++;
      tick();
      cyc++;
    end
    check({tag, " err pulses"}, 32'(n_err), 32'd1);
    check({tag, " err cycle"}, 32'(t_err), 32'(exp_cyc));
    check({tag, " no tt_valid"}, 32'(n_valid), 32'd0);
    check({tag, " busy after err"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int nw;
    int cyc;
    int n_valid;

    // Full reference netlist: w0..w5 as below, output w5 (code 13).
    vecs[0] = '0;
    vecs[0].op_a = {4'd2, 4'd7, 4'd1, 4'd1, 4'd1, 4'd2};
    vecs[0].op_b = {4'd9, 4'd10, 4'd3, 4'd6, 4'd3, 4'd3};
    vecs[0].op_c = {4'd12, 4'd11, 4'd4, 4'd8, 4'd5, 4'd4};
    vecs[0].out_sel = 4'd13;
    vecs[0].exp = {32'hfeeaece8, 32'hfae8e8a0, 32'hfae8e8a0, 32'he8c8a880};
    vecs[1] = mk1(1, 2, 3, 3'b000, 8, 1'b0, {4{32'he8e8e8e8}});
    vecs[2] = mk1(1, 2, 3, 3'b000, 8, 1'b1, {4{32'h17171717}});
    vecs[3] = mk1(0, 0, 0, 3'b000, 0, 1'b1, {4{32'hffffffff}});
    vecs[4] = mk1(0, 0, 0, 3'b000, 1, 1'b0, {4{32'haaaaaaaa}});
    vecs[5] = mk1(0, 0, 0, 3'b000, 5, 1'b0, {4{32'hffff0000}});
    vecs[6] = mk1(0, 0, 0, 3'b000, 7, 1'b0, {32'hffffffff, 32'hffffffff, 32'h0, 32'h0});
    vecs[7] = mk1(1, 1, 2, 3'b010, 8, 1'b0, {4{32'hcccccccc}});
    vecs[8] = mk1(0, 0, 0, 3'b000, 6, 1'b0, {32'hffffffff, 32'h0, 32'hffffffff, 32'h0});
    vecs[9] = mk1(1, 2, 3, 3'b111, 8, 1'b0, {4{32'h17171717}});

    i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset tt_valid", 32'(o_tt_valid), 32'd0);
    check("reset tt_last", 32'(o_tt_last), 32'd0);
    check("reset tt_data", o_tt_data, 32'd0);
    check("reset done", 32'(o_done), 32'd0);
    check("reset err", 32'(o_err), 32'd0);

    for (int v = 0; v < N_VEC; v++) begin
      apply(vecs[v]);
      sweep($sformatf("vec%0d", v), vecs[v].exp, 0, 1'b0);
    end

    apply(vecs[0]);
    sweep("stall20", vecs[0].exp, 20, 1'b0);
    sweep("stall40", vecs[0].exp, 40, 1'b0);
    sweep("poke", vecs[0].exp, 0, 1'b1);
    sweep("after poke", vecs[0].exp, 0, 1'b0);

    wr_node(2, 11, 6, 8, 3'b000);
    expect_err("fwd ref", 3);
    wr_node(2, 1, 6, 8, 3'b000);
    wr_node(0, 2, 3, 8, 3'b000);
    expect_err("self ref", 1);
    wr_node(0, 2, 3, 4, 3'b000);
    wr_node(5, 14, 9, 12, 3'b000);
    expect_err("code past last node", 6);
    wr_node(5, 2, 9, 12, 3'b000);
    wr_out(14, 1'b0);
    expect_err("bad out_sel", 7);
    wr_out(13, 1'b0);
    sweep("recovered", vecs[0].exp, 0, 1'b0);

    // Reset after the second word has been handed over.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    nw  = 0;
    cyc = 0;
    while (nw < 2 && cyc < 1000) begin
      if (o_tt_valid && i_tt_ready) nw++;
      tick();
      cyc++;
    end
    check("midrst words before", 32'(nw), 32'd2);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("midrst tt_valid", 32'(o_tt_valid), 32'd0);
    check("midrst busy", 32'(o_busy), 32'd0);
    check("midrst tt_data", o_tt_data, 32'd0);
    n_valid = 0;
    for (int c = 0; c < 120; c++) begin
      if (o_tt_valid) n_valid++;
      tick();
    end
    check("midrst no more words", 32'(n_valid), 32'd0);
    sweep("cleared out_sel", {4{32'h0}}, 0, 1'b0);
    wr_out(13, 1'b0);
    sweep("cleared nodes", {4{32'h0}}, 0, 1'b0);
    wr_out(0, 1'b1);
    sweep("const1", {4{32'hffffffff}}, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mig_tt_engine.md
MIG_TT_ENGINE -- requirements
Module: mig_tt_engine

Interface
REQ-001 Parameter N_IN, default 7: number of primary inputs x0..x(N_IN-1).
REQ-002 Parameter N_NODES, default 6: number of configurable majority nodes w0..w(N_NODES-1).
REQ-003 Parameter OUT_W, default 32: truth-table word width; 2^N_IN SHALL be a multiple of OUT_W (elaboration error otherwise).
REQ-004 Derived SEL_W = clog2(1+N_IN+N_NODES); NODE_W = clog2(N_NODES).
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cfg_we  in  1  write node config; cfg_node  in  NODE_W  node index.
REQ-008 cfg_op_a, cfg_op_b, cfg_op_c  in  SEL_W each  operand selects; cfg_inv  in  3  per-operand complement {c,b,a}.
REQ-009 cfg_out_sel  in  SEL_W, cfg_out_inv  in  1, cfg_out_we  in  1  output-signal select/complement write.
REQ-010 start  in  1  begin sweep; busy  out  1  engine not in IDLE.
REQ-011 tt_valid  out  1, tt_ready  in  1, tt_data  out  OUT_W, tt_last  out  1  truth-table word stream.
REQ-012 done  out  1  one-cycle pulse at end of sweep; err  out  1  one-cycle pulse on illegal config.

Function
REQ-013 Operand encoding SHALL be: 0 = const 0; 1..N_IN = x(k-1); N_IN+1.. = w(k-N_IN-1); codes above last node illegal.
REQ-014 Node j SHALL compute MAJ(a',b',c'), each operand XORed with its cfg_inv bit.
REQ-015 Node j referencing any w(m) with m >= j SHALL be illegal (acyclic, topological order).
REQ-016 Config writes SHALL take effect next cycle and SHALL be ignored while busy=1.
REQ-017 FSM states IDLE, CHECK, SWEEP, FLUSH; start ignored unless IDLE.
REQ-018 IDLE --start--> CHECK; CHECK examines node j in cycle j (N_NODES cycles), then output select.
REQ-019 Any illegal operand/out_sel: err pulses 1 cycle, FSM returns to IDLE, no tt_valid.
REQ-020 CHECK passes -> SWEEP; minterm counter m runs 0..2^N_IN-1, one minterm per non-stalled cycle, x_i = bit i of m.
REQ-021 Node chain evaluates combinationally within the cycle; f(m) = selected signal XOR cfg_out_inv.
REQ-022 f(m) SHALL be placed at bit (m mod OUT_W) of word floor(m/OUT_W); words emitted in ascending index.
REQ-023 Accumulator plus one output register: full accumulator moves to output register when it is empty or being consumed that cycle; otherwise SWEEP stalls (m holds).
REQ-024 tt_data/tt_last SHALL be stable while tt_valid=1 and tt_ready=0; transfer on tt_valid&tt_ready.
REQ-025 tt_last SHALL be 1 only on word 2^N_IN/OUT_W - 1.
REQ-026 After last minterm -> FLUSH; on handshake of tt_last word, done pulses and FSM -> IDLE in the same edge.
REQ-027 With tt_ready held 1: first tt_valid exactly N_NODES+1+OUT_W cycles after start sampled; words back-to-back every OUT_W cycles.

Reset
REQ-028 On rst: FSM=IDLE, m=0, accumulator/output register cleared, busy/tt_valid/tt_last/done/err=0, tt_data=0.
REQ-029 On rst: all node configs and out_sel cleared to 0 (const 0, no inversion); applies mid-sweep, no further words emitted.

Structure
REQ-030 Package mig_pkg SHALL hold operand-code constants (SEL_CONST0, SEL_X_BASE, SEL_W_BASE function), node config struct {op_a, op_b, op_c, inv}, FSM state enum.
REQ-031 Single sub-module mig_node: three operands, three invert bits, majority output; instantiated N_NODES times.

Verification
REQ-032 Config w0=M(x1,x2,x3), w1=M(x0,x2,x4), w2=M(x0,x5,w0), w3=M(x0,x2,x3), w4=M(x6,w2,w3), w5=M(x1,w1,w4), out=w5, ready=1 -> words 32'he8c8a880, 32'hfae8e8a0, 32'hfae8e8a0, 32'hfeeaece8, tt_last on 4th, done 1 cycle later-edge.
REQ-033 Single node w0=M(x0,x1,x2), out=w0 -> four words 32'he8e8e8e8; out_inv=1 -> 32'h17171717.
REQ-034 Same as REQ-032 with tt_ready=0 for 20 cycles after first tt_valid -> tt_data held 32'he8c8a880, busy=1, identical four-word sequence afterward.
REQ-035 Node 2 op_a = code of w3, start -> err pulse after CHECK, busy returns 0, zero tt_valid.
REQ-036 rst asserted after 2nd word of REQ-032 -> next cycle tt_valid=0, busy=0; start with out_inv=1 only -> four words 32'hffffffff.
REQ-037 cfg_we pulses during SWEEP -> sweep output unchanged from REQ-032.
